// File: rtl/serial_adder.sv
`timescale 1ns / 1ps
// serial_adder
// Bit-serial adder/subtractor. One full-adder bit is evaluated per clock,
// LSB first, with a single carry flip-flop. Subtraction is done as
// a + ~b + 1 by inverting b at latch time and presetting the carry.
//
// Parameters
//   WIDTH   operand/result width in bits (2..32)
//   SUB_EN  1 enables subtract mode, 0 forces add-only (sub ignored)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin an operation (accepted only in IDLE)
//   sub        0 = a+b, 1 = a-b, sampled with start
//   a, b       operands, sampled with start
//   busy       high while an operation is in progress
//   done       single-cycle result-valid pulse
//   sum        result register (partial while shifting)
//   carry_out  final carry (add) or no-borrow flag (sub)
//   overflow   two's-complement signed overflow of the result
//
// Timing: with start sampled at edge N, the WIDTH shift steps occur at
// edges N+1..N+WIDTH, the FSM sits in DONE for one cycle, and the registered
// status outputs present done during the cycle after edge N+WIDTH+1. busy is
// high for the WIDTH+1 cycles ending with the done cycle. A start held through
// the done cycle is accepted, giving one result per WIDTH+2 cycles.
module serial_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CntW-1:0]  cnt;

    logic eff_sub;
    logic bit_sum;
    logic bit_carry;

    // One full-adder slice on the current operand LSBs.
    always_comb begin
        eff_sub   = SUB_EN & sub;
        bit_sum   = op_a[0] ^ op_b[0] ^ carry;
        bit_carry = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Status outputs are registered copies of the current state.
            busy <= (state != StIdle);
            done <= (state == StDone);

            unique case (state)
                StIdle: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= eff_sub ? ~b : b;
                        carry <= eff_sub;  // the +1 of two's-complement negation
                        cnt   <= '0;
                        state <= StShift;
                    end
                end
                StShift: begin
                    sum   <= {bit_sum, sum[WIDTH-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= bit_carry;
                    cnt   <= cnt + CntW'(1);
                    if (cnt == LastBit) begin
                        // carry currently holds the carry into the MSB.
                        carry_out <= bit_carry;
                        overflow  <= carry ^ bit_carry;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Parameter SUB_EN, default 1, 1 enables subtract mode, 0 forces add-only (sub input ignored).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin an operation, sampled on rising clk.
REQ-006 sub  input  1  operation select, 0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  WIDTH  operand A, sampled with start.
REQ-008 b  input  WIDTH  operand B, sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse, result valid.
REQ-011 sum  output  WIDTH  result register.
REQ-012 carry_out  output  1  final carry (add) or no-borrow flag (sub).
REQ-013 overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-014 Block SHALL compute the result bit-serially, one full-adder bit per clock, LSB first, using one carry flip-flop.
REQ-015 FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE: start=1 -> latch a, b (b bitwise-inverted when sub=1 and SUB_EN=1), carry preset to effective sub, bit counter cleared, go SHIFT.
REQ-017 SHIFT: each cycle add operand LSBs plus carry, shift result bit into sum MSB (sum shifts right), shift both operands right, update carry, increment counter.
REQ-018 SHIFT -> DONE after exactly WIDTH SHIFT cycles; counter width ceil(log2(WIDTH+1)).
REQ-019 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 Latency: start sampled at edge N -> done high during cycle after edge N+WIDTH+1.
REQ-021 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-022 start while busy=1 (SHIFT or DONE) SHALL be ignored; no latch, no restart; a, b, sub changes during operation have no effect.
REQ-023 start in the cycle after done (IDLE) SHALL be accepted; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-024 sum, carry_out, overflow SHALL hold their final values from DONE until the next accepted start.
REQ-025 During SHIFT, sum is a partial value and SHALL NOT be interpreted; carry_out/overflow update only on SHIFT->DONE.
REQ-026 carry_out = carry out of bit WIDTH-1; overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-027 Arithmetic modulo 2^WIDTH; no saturation.
REQ-028 SUB_EN=0: sub treated as 0 in all cases.

Reset
REQ-029 rst=1 SHALL immediately, without clk, force state IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, counter=0, internal operand and carry registers 0.
REQ-030 rst asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse produced; first start after rst deassertion is accepted normally.
REQ-031 start coincident with rst SHALL be ignored.

Verification (WIDTH=8, SUB_EN=1 unless stated)
REQ-032 Add: a=0x3C, b=0x15, sub=0, start 1 cycle -> busy for 9 cycles, done on 10th cycle after start edge, sum=0x51, carry_out=0, overflow=0.
REQ-033 Add wrap: a=0xFF, b=0x01 -> sum=0x00, carry_out=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, carry_out=0, overflow=1.
REQ-034 Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0 (borrow), overflow=0; a=0x80, b=0x01 -> sum=0x7F, carry_out=1, overflow=1.
REQ-035 Ignored start: start pulse with new operands 3 cycles into SHIFT -> first result unchanged, exactly one done pulse, busy drops after it; start one cycle later accepted.
REQ-036 Reset mid-op: rst asserted asynchronously 4 cycles into SHIFT -> outputs zero before next clk edge, no done; subsequent a=0x01, b=0x01 -> sum=0x02.
REQ-037 Parameter sweep: WIDTH=2, 16, 32 and SUB_EN=0 with sub=1 -> random operands match reference model a+b mod 2^WIDTH, done latency WIDTH+1 edges.
